// File: rtl/fft_pkg.sv
// Shared types and helpers for the sequential 8-point FFT.
// Holds the FSM state encoding, index bit reversal and the W8 twiddle constant.
package fft_pkg;

    typedef enum logic [2:0] {
        LOAD,
        S1,
        S2,
        S3,
        UNLOAD
    } fft_state_t;

    typedef struct {
        int re;
        int im;
    } cplx_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

    // C = round(cos(pi/4) * 2^frac)
    function automatic int tw_const(input int frac);
        return $rtoi(0.70710678 * (2.0 ** frac) + 0.5);
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 butterfly: top = a + W*b, bot = a - W*b, W = W8^tw.
// W8^0 and W8^2 need no multiplier; W8^1 and W8^3 use the rounded constant C.
import fft_pkg::*;

module fft_bfly #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14,
    parameter int SCALE   = 0
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic        [1:0]        tw,
    output logic signed [DATA_W-1:0] top_re,
    output logic signed [DATA_W-1:0] top_im,
    output logic signed [DATA_W-1:0] bot_re,
    output logic signed [DATA_W-1:0] bot_im
);

    localparam int PW = 2 * DATA_W + 2;
    localparam logic signed [PW-1:0] C    = PW'(tw_const(TW_FRAC));
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW_FRAC - 1));

    logic signed [PW-1:0]     p_w, q_w, sum_c, dif_c, r_sum, r_dif, r_nsum;
    logic signed [DATA_W-1:0] wb_re, wb_im;
    logic signed [DATA_W:0]   t_re, t_im, u_re, u_im;

    always_comb begin
        p_w    = PW'(b_re);
        q_w    = PW'(b_im);
        sum_c  = (p_w + q_w) * C;
        dif_c  = (q_w - p_w) * C;
        r_sum  = (sum_c + HALF) >>> TW_FRAC;
        r_dif  = (dif_c + HALF) >>> TW_FRAC;
        r_nsum = (-sum_c + HALF) >>> TW_FRAC;

        wb_re = b_re;
        wb_im = b_im;
        unique case (tw)
            2'd1: begin
                wb_re = r_sum[DATA_W-1:0];
                wb_im = r_dif[DATA_W-1:0];
            end
            2'd2: begin
                wb_re = b_im;
                wb_im = -b_re;
            end
            2'd3: begin
                wb_re = r_dif[DATA_W-1:0];
                wb_im = r_nsum[DATA_W-1:0];
            end
            default: ;
        endcase

        // One guard bit keeps the exact sum so SCALE=1 halves without overflow
        t_re = {a_re[DATA_W-1], a_re} + {wb_re[DATA_W-1], wb_re};
        t_im = {a_im[DATA_W-1], a_im} + {wb_im[DATA_W-1], wb_im};
        u_re = {a_re[DATA_W-1], a_re} - {wb_re[DATA_W-1], wb_re};
        u_im = {a_im[DATA_W-1], a_im} - {wb_im[DATA_W-1], wb_im};

        if (SCALE != 0) begin
            top_re = t_re[DATA_W:1];
            top_im = t_im[DATA_W:1];
            bot_re = u_re[DATA_W:1];
            bot_im = u_im[DATA_W:1];
        end else begin
            top_re = t_re[DATA_W-1:0];
            top_im = t_im[DATA_W-1:0];
            bot_re = u_re[DATA_W-1:0];
            bot_im = u_im[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fft8_seq.sv
// Sequential 8-point radix-2 DIT FFT: bit-reversed load, three in-place stages,
// natural-order unload over a valid/ready stream.
import fft_pkg::*;

module fft8_seq #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14,
    parameter int SCALE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [2:0]        out_index,
    output logic              out_last
);

    fft_state_t state, state_nxt;
    logic [2:0] cnt;

    logic signed [DATA_W-1:0] mem_re [8];
    logic signed [DATA_W-1:0] mem_im [8];

    logic [2:0]               ia [4];
    logic [2:0]               ib [4];
    logic [1:0]               tw_sel [4];
    logic signed [DATA_W-1:0] a_re [4], a_im [4], b_re [4], b_im [4];
    logic signed [DATA_W-1:0] top_re [4], top_im [4], bot_re [4], bot_im [4];

    // Per-stage pair selection for the four butterflies
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ia[i]     = 3'(2 * i);
            ib[i]     = 3'(2 * i + 1);
            tw_sel[i] = 2'd0;
            unique case (state)
                S2: begin
                    ia[i]     = 3'(4 * (i / 2) + i % 2);
                    ib[i]     = 3'(4 * (i / 2) + i % 2 + 2);
                    tw_sel[i] = 2'(2 * (i % 2));
                end
                S3: begin
                    ia[i]     = 3'(i);
                    ib[i]     = 3'(i + 4);
                    tw_sel[i] = 2'(i);
                end
                default: ;
            endcase
            a_re[i] = mem_re[ia[i]];
            a_im[i] = mem_im[ia[i]];
            b_re[i] = mem_re[ib[i]];
            b_im[i] = mem_im[ib[i]];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bfly
        fft_bfly #(
            .DATA_W (DATA_W),
            .TW_FRAC(TW_FRAC),
            .SCALE  (SCALE)
        ) u_bfly (
            .a_re  (a_re[g]),
            .a_im  (a_im[g]),
            .b_re  (b_re[g]),
            .b_im  (b_im[g]),
            .tw    (tw_sel[g]),
            .top_re(top_re[g]),
            .top_im(top_im[g]),
            .bot_re(bot_re[g]),
            .bot_im(bot_im[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == 3'd7) state_nxt = S1;
            end
            S1: state_nxt = S2;
            S2: state_nxt = S3;
            S3: state_nxt = UNLOAD;
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && cnt == 3'd7) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
        out_real  = out_valid ? mem_re[cnt] : '0;
        out_imag  = out_valid ? mem_im[cnt] : '0;
        out_index = out_valid ? cnt : '0;
        out_last  = out_valid && cnt == 3'd7;
    end

    // cnt wraps 7 -> 0, which clears it at the end of both load and unload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem_re[bitrev3(cnt)] <= in_real;
                        mem_im[bitrev3(cnt)] <= in_imag;
                        cnt <= cnt + 3'd1;
                    end
                end
                S1, S2, S3: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        mem_re[ia[i]] <= top_re[i];
                        mem_im[ia[i]] <= top_im[i];
                        mem_re[ib[i]] <= bot_re[i];
                        mem_im[ib[i]] <= bot_im[i];
                    end
                end
                UNLOAD: begin
                    if (out_ready) cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
